// File: rtl/shift_sequencer.sv
// Sequences an 8-bit LED shifter: initialises it, then issues rate-divided
// one-cycle shift commands, with a bounce mode that reverses at the end bits.
module shift_sequencer #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [7:0]       steps,
  input  logic [DIV_W-1:0] div,
  input  logic             stop,
  input  logic [7:0]       sh_q,
  output logic             sh_reset,
  output logic [2:0]       sh_sel,
  output logic             busy,
  output logic             done,
  output logic [7:0]       step_cnt
);

  localparam logic [2:0] SEL_SLL     = 3'd1;
  localparam logic [2:0] SEL_SRL     = 3'd2;
  localparam logic [2:0] MODE_BOUNCE = 3'd7;

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       mode_q;
  logic [7:0]       steps_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;
  logic             dir_left;
  logic             accept;
  logic             shift_ev;
  logic             last_step;
  logic [2:0]       code;
  logic             sh_q_unused;

  // Only the end bits of the shifter matter for the bounce decision.
  assign sh_q_unused = ^sh_q[6:1];

  assign accept    = (state == IDLE) && start && (mode != '0);
  assign shift_ev  = (state == RUN) && (presc == div_q);
  assign last_step = shift_ev && (steps_q != '0) && ((step_cnt + 8'd1) == steps_q);

  always_comb begin
    code = mode_q;
    if (mode_q == MODE_BOUNCE) begin
      if (!dir_left) code = sh_q[0] ? SEL_SLL : SEL_SRL;
      else           code = sh_q[7] ? SEL_SRL : SEL_SLL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode_q   <= '0;
      steps_q  <= '0;
      div_q    <= '0;
      presc    <= '0;
      dir_left <= 1'b0;
      step_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q   <= mode;
        steps_q  <= steps;
        div_q    <= div;
        presc    <= '0;
        dir_left <= 1'b0;
        step_cnt <= '0;
      end else if (state == RUN) begin
        if (shift_ev) begin
          presc    <= '0;
          step_cnt <= step_cnt + 8'd1;
          // Direction follows the command just issued: SLL means heading left.
          if (mode_q == MODE_BOUNCE) dir_left <= (code == SEL_SLL);
        end else begin
          presc <= presc + DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = INIT;
      INIT: state_nxt = stop ? DONE : RUN;
      RUN:  if (stop || last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sh_reset = (state == INIT);
    busy     = (state == INIT) || (state == RUN);
    done     = (state == DONE);
    sh_sel   = shift_ev ? code : '0;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a shifter model closes the loop, and a per-program
// trace predicted from the program rules is compared every cycle.
module tb_shift_sequencer;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [2:0]    mode = '0;
  logic [7:0]    steps = '0;
  logic [DW-1:0] div = '0;
  logic [7:0]    sh_q = '0;
  logic          sh_reset;
  logic [2:0]    sh_sel;
  logic          busy;
  logic          done;
  logic [7:0]    step_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cycles = 0;
  int done_pulses = 0;
  logic [7:0] hold_cnt = '0;

  typedef struct {
    int         cyc;
    logic       rst;
    logic [2:0] sel;
    logic       bsy;
    logic       dn;
    logic [7:0] cnt;
  } exp_t;

  exp_t expq[$];

  shift_sequencer #(.DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .steps(steps),
    .div(div), .stop(stop), .sh_q(sh_q), .sh_reset(sh_reset), .sh_sel(sh_sel),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] shift8(input logic [7:0] q, input logic [2:0] s);
    case (s)
      3'd1: return {q[6:0], 1'b0};
      3'd2: return {1'b0, q[7:1]};
      3'd3: return {q[6:0], q[0]};
      3'd4: return {q[7], q[7:1]};
      3'd5: return {q[6:0], q[7]};
      3'd6: return {q[0], q[7:1]};
      default: return q;
    endcase
  endfunction

  // External shifter: synchronous reset, not touched by the controller reset.
  always @(posedge clk) begin
    if (sh_reset) sh_q <= 8'h80;
    else          sh_q <= shift8(sh_q, sh_sel);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Predicted per-cycle outputs for a program accepted at the edge ending cycle c.
  task automatic build_trace(input int c, input logic [2:0] m, input logic [7:0] st,
                             input int dv, input int stop_rel,
                             output int done_cyc, output logic [7:0] final_q);
    exp_t       e;
    logic [7:0] q;
    logic [7:0] n;
    logic [2:0] code;
    bit         left;
    bit         fin;
    bit         ev;
    int         r;
    q = 8'h80; n = '0; left = 0; r = 0;
    e = '{c + 1, 1'b1, 3'd0, 1'b1, 1'b0, 8'd0};
    expq.push_back(e);
    fin = (stop_rel == 0);
    while (!fin && r < 5000) begin
      ev = ((r % (dv + 1)) == dv);
      code = 3'd0;
      if (ev) begin
        if (m == 3'd7) begin
          if (!left) code = q[0] ? 3'd1 : 3'd2;
          else       code = q[7] ? 3'd2 : 3'd1;
          left = (code == 3'd1);
        end else begin
          code = m;
        end
      end
      e = '{c + 2 + r, 1'b0, code, 1'b1, 1'b0, n};
      expq.push_back(e);
      if (ev) begin
        q = shift8(q, code);
        n = n + 8'd1;
        if (st != 0 && n == st) fin = 1;
      end
      if (stop_rel == r + 1) fin = 1;
      r++;
    end
    e = '{c + 2 + r, 1'b0, 3'd0, 1'b0, 1'b1, n};
    expq.push_back(e);
    done_cyc = c + 2 + r;
    final_q = q;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      expq.delete();
      hold_cnt = '0;
    end
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      if (e.dn) hold_cnt = e.cnt;
    end else begin
      e = '{cyc, 1'b0, 3'd0, 1'b0, 1'b0, hold_cnt};
    end
    check("outputs{rst,sel,busy,done,cnt}", {sh_reset, sh_sel, busy, done, step_cnt},
          {e.rst, e.sel, e.bsy, e.dn, e.cnt});
    if (busy) busy_cycles++;
    if (done) done_pulses++;
  end

  task automatic run_prog(input logic [2:0] m, input logic [7:0] st, input int dv,
                          input int stop_rel, input int xs_rel, output logic [7:0] fq);
    int c;
    int dc;
    @(posedge clk); #1;
    c = cyc; start = 1'b1; mode = m; steps = st; div = DW'(dv);
    build_trace(c, m, st, dv, stop_rel, dc, fq);
    for (int k = 0; c + 1 + k <= dc; k++) begin
      @(posedge clk); #1;
      start = (k == xs_rel);
      stop  = (k == stop_rel);
      if (k == 0) begin
        mode = 3'($urandom); steps = 8'($urandom); div = DW'($urandom_range(0, 7));
      end
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    logic [7:0] fq;
    int b0, d0, c, dc;
    #1 reset = 1'b0;
    #1 check("reset_state", {sh_reset, sh_sel, busy, done, step_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    b0 = busy_cycles; d0 = done_pulses;
    run_prog(3'd2, 8'd3, 0, -1, -1, fq);
    check("srl3_sh_q", sh_q, 8'h10);
    check("srl3_model_q", fq, 8'h10);
    check("srl3_step_cnt", step_cnt, 8'd3);
    check("srl3_busy_cycles", busy_cycles - b0, 4);
    check("srl3_done_pulses", done_pulses - d0, 1);

    d0 = done_pulses;
    run_prog(3'd5, 8'd8, 2, -1, -1, fq);
    check("rol8_sh_q", sh_q, 8'h80);
    check("rol8_step_cnt", step_cnt, 8'd8);
    check("rol8_done_pulses", done_pulses - d0, 1);

    run_prog(3'd7, 8'd10, 0, -1, -1, fq);
    check("bounce_sh_q", sh_q, 8'h08);
    check("bounce_model_q", fq, 8'h08);
    check("bounce_step_cnt", step_cnt, 8'd10);

    run_prog(3'd6, 8'd0, 3, 82, -1, fq);
    check("ror_cont_step_cnt", step_cnt, 8'd20);
    check("ror_cont_sh_q", sh_q, 8'h08);

    run_prog(3'd3, 8'd5, 1, -1, 3, fq);
    check("busy_start_step_cnt", step_cnt, 8'd5);
    check("busy_start_sh_q", sh_q, fq);
    b0 = busy_cycles; d0 = done_pulses;
    @(posedge clk); #1; start = 1'b1; mode = 3'd0; steps = 8'd2;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mode0_busy", busy_cycles - b0, 0);
    check("mode0_done", done_pulses - d0, 0);
    check("mode0_step_cnt", step_cnt, 8'd5);

    d0 = done_pulses;
    run_prog(3'd1, 8'd9, 2, 0, -1, fq);
    check("stop_init_step_cnt", step_cnt, 8'd0);
    check("stop_init_done", done_pulses - d0, 1);

    run_prog(3'd5, 8'd0, 0, 300, -1, fq);
    check("wrap_step_cnt", step_cnt, 8'd44);
    check("wrap_sh_q", sh_q, 8'h08);

    @(posedge clk); #1;
    c = cyc; start = 1'b1; mode = 3'd1; steps = 8'd10; div = '0;
    build_trace(c, 3'd1, 8'd10, 0, -1, dc, fq);
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("pre_reset_step_cnt", step_cnt, 8'd5);
    #6 reset = 1'b0;
    #1 check("async_reset_outputs", {sh_reset, sh_sel, busy, done, step_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    run_prog(3'd2, 8'd4, 1, -1, -1, fq);
    check("post_reset_sh_q", sh_q, 8'h08);
    check("post_reset_step_cnt", step_cnt, 8'd4);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] m;
      logic [7:0] st;
      int dv, sr, xr;
      m  = 3'($urandom_range(1, 7));
      st = 8'($urandom_range(0, 12));
      dv = $urandom_range(0, 3);
      if (st == 0)                   sr = $urandom_range(0, 40);
      else if ($urandom_range(0, 1)) sr = -1;
      else                           sr = $urandom_range(0, 60);
      xr = $urandom_range(0, 1) ? -1 : $urandom_range(0, 20);
      run_prog(m, st, dv, sr, xr, fq);
      check("rand_sh_q", sh_q, fq);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller that sequences the 8-bit LED shifter for the FPGA board: it accepts a shift program (mode, step count, rate) via a start/busy/done handshake. It initialises the shifter to 8'b10000000, then issues one-cycle shift commands at a programmable rate, and adds a hardware "bounce" mode by watching the shifter output. It sits between the board control logic (buttons/switch decode) and the shifter's `reset`/`sel` inputs.

## Interface
- DIV_W, 24, width of the rate divider; shift event every `div+1` clk cycles
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; low forces IDLE and all outputs to 0 immediately
- start  in  1  program request; sampled only in IDLE
- mode  in  3  1=SLL, 2=SRL, 3=SLA, 4=SRA, 5=ROL, 6=ROR (shifter sel codes), 7=bounce, 0=invalid
- steps  in  8  number of shift events; 0 = continuous until `stop`
- div  in  DIV_W  rate divider reload value
- stop  in  1  abort/finish request while busy
- sh_q  in  8  shifter `c_out`
- sh_reset  out  1  to shifter `reset` (sync, active-high); 1-cycle pulse
- sh_sel  out  3  to shifter `sel`; nonzero for exactly one cycle per shift event
- busy  out  1  high in INIT and RUN
- done  out  1  one-cycle completion pulse
- step_cnt  out  8  shift events issued in the current program

## Operation
- States: IDLE, INIT, RUN, DONE. Reset state IDLE; reset values: sh_reset=0, sh_sel=0, busy=0, done=0, step_cnt=0, prescaler=0, dir=right.
- IDLE: start=1 and mode!=0 -> latch mode/steps/div, clear step_cnt, prescaler, dir=right -> INIT. start with mode=0 is ignored (stay IDLE, no done).
- INIT (1 cycle): sh_reset=1, sh_sel=0; shifter loads 10000000 at end of cycle -> RUN.
- RUN: prescaler counts 0..div_latched; cycle where prescaler==div is the event cycle: sh_sel=code (combinational from state/prescaler/dir/sh_q), step_cnt+1, prescaler->0. Non-event cycles: sh_sel=0.
- Modes 1-6: code = mode.
- Bounce (7): in event cycle, dir=right and sh_q[0]=1 -> code=1 (SLL), dir<=left; dir=left and sh_q[7]=1 -> code=2 (SRL), dir<=right; otherwise code=2 if dir=right, 1 if left.
- Completion: steps!=0 and event cycle takes step_cnt to steps -> DONE. steps=0: step_cnt wraps 255->0, runs until stop.
- stop=1 in INIT or RUN -> DONE at next edge; an event in the same cycle is still issued and counted. stop in IDLE/DONE ignored.
- DONE (1 cycle): done=1, busy=0, sh_sel=0 -> IDLE. step_cnt holds until next accepted start.
- start while busy or in DONE: ignored, latched program unchanged.
- Reset low mid-program: immediate IDLE, outputs 0; shifter contents are not cleared (its reset is synchronous, driven by sh_reset).

## Timing
- start accepted at edge k -> INIT (sh_reset=1) in cycle k+1 -> RUN from k+2.
- First event in RUN cycle index div (0-based); subsequent events every div+1 cycles.
- sh_sel asserted in cycle t -> shifter updates at end of t -> sh_q valid at t+1, so bounce decisions are correct for div=0.
- Final event at cycle t -> done=1 in t+1 -> IDLE in t+2; earliest next accepted start at edge ending t+2.
- Only combinational input->output path: sh_q -> sh_sel (bounce mode).

## Test plan
- mode=2, steps=3, div=0: sh_reset 1 cycle, then sh_sel=2 for 3 consecutive cycles, done next cycle; sh_q=00010000, step_cnt=3, busy high exactly 4 cycles.
- mode=5, steps=8, div=2: sh_sel=5 pulses every 3 cycles (8 pulses), final sh_q=10000000, one done pulse.
- mode=7, steps=10, div=0: sh_q walks 0x40..0x01 (7 SRL), then sh_sel=1 three times -> 0x02,0x04,0x08; done, step_cnt=10.
- mode=6, steps=0, div=3: runs continuously; stop raised in a non-event cycle after 20 events -> done next cycle, step_cnt=20, sh_q=pattern after 20 RORs (00001000).
- start pulsed while busy and start with mode=0 in IDLE: both ignored (no sh_reset, no done, program unchanged).
- reset driven low mid-RUN (step 5 of 10): busy/sh_sel/done/step_cnt go 0 without clk edge; after release, state IDLE, new start runs normally from INIT.
